// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: FSM state
// encodings, default abort timeout and fixed field widths.
package mem_arbiter_pkg;

  // Arbiter FSM states. IDLE must stay at zero so reset lands there.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_ACC  = 2'd1,
    ST_MEM_ACC = 2'd2
  } arb_state_e;

  // Bus cycles to wait for bus_ack_i before aborting an access.
  localparam int unsigned TIMEOUT_DEFAULT = 32'd16;

  // Byte-enable width of the bus and the data port.
  localparam int unsigned SEL_W = 32'd4;

  // Instruction fetches always read a full word.
  localparam logic [SEL_W-1:0] FETCH_SEL = 4'hF;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: arbitrates an instruction-fetch port and a
// load/store port onto one external bus, data port first. The bus request is
// registered and held for the whole access; each access ends on bus_ack_i or
// on an abort after TIMEOUT bus cycles. Fetches can be flushed in flight.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned DW      = 32
) (
  input  logic             clk,
  input  logic             rst,
  // instruction fetch port
  input  logic             if_ce_i,
  input  logic [DW-1:0]    if_addr_i,
  input  logic             if_flush_i,
  output logic [DW-1:0]    if_data_o,
  output logic             if_ack_o,
  // data port
  input  logic             mem_ce_i,
  input  logic             mem_we_i,
  input  logic [DW-1:0]    mem_addr_i,
  input  logic [SEL_W-1:0] mem_sel_i,
  input  logic [DW-1:0]    mem_wdata_i,
  output logic [DW-1:0]    mem_rdata_o,
  output logic             mem_ack_o,
  // external bus
  output logic             bus_cyc_o,
  output logic             bus_we_o,
  output logic [DW-1:0]    bus_addr_o,
  output logic [SEL_W-1:0] bus_sel_o,
  output logic [DW-1:0]    bus_wdata_o,
  input  logic [DW-1:0]    bus_rdata_i,
  input  logic             bus_ack_i,
  output logic             bus_err_o,
  // pipeline stall request
  output logic             stallreq_o
);

  localparam int unsigned CW = (TIMEOUT > 32'd2) ? $clog2(TIMEOUT) : 32'd1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 32'd1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);
  localparam logic [DW-1:0] DATA_ZERO = {DW{1'b0}};

  arb_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             discard_q, discard_d;
  logic             bus_cyc_q, bus_cyc_d;
  logic             bus_we_q, bus_we_d;
  logic [DW-1:0]    bus_addr_q, bus_addr_d;
  logic [SEL_W-1:0] bus_sel_q, bus_sel_d;
  logic [DW-1:0]    bus_wdata_q, bus_wdata_d;
  logic [DW-1:0]    if_data_q, if_data_d;
  logic             if_ack_q, if_ack_d;
  logic [DW-1:0]    mem_rdata_q, mem_rdata_d;
  logic             mem_ack_q, mem_ack_d;
  logic             bus_err_q, bus_err_d;

  logic             if_req_s;
  logic             mem_req_s;
  logic             timeout_s;
  logic             finish_s;

  // A requester is still holding ce during its own ack cycle; masking with the
  // ack flop keeps that already-served request from starting a second access.
  assign if_req_s  = if_ce_i & ~if_ack_q;
  assign mem_req_s = mem_ce_i & ~mem_ack_q;
  assign timeout_s = (cnt_q == CNT_LAST);
  // An ack on the timeout cycle still counts as a normal completion.
  assign finish_s  = bus_ack_i | timeout_s;

  // Next-state, bus request and completion logic for the arbiter FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    discard_d   = discard_q;
    bus_cyc_d   = bus_cyc_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_sel_d   = bus_sel_q;
    bus_wdata_d = bus_wdata_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    bus_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // bus_ack_i and if_flush_i have no meaning here and are ignored.
        cnt_d     = CNT_ZERO;
        discard_d = 1'b0;
        if (mem_req_s) begin
          state_d     = ST_MEM_ACC;
          bus_cyc_d   = 1'b1;
          bus_we_d    = mem_we_i;
          bus_addr_d  = mem_addr_i;
          bus_sel_d   = mem_sel_i;
          bus_wdata_d = mem_wdata_i;
        end else if (if_req_s) begin
          state_d     = ST_IF_ACC;
          bus_cyc_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr_i;
          bus_sel_d   = FETCH_SEL;
          bus_wdata_d = DATA_ZERO;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_IF_ACC: begin
        if (finish_s) begin
          state_d   = ST_IDLE;
          bus_cyc_d = 1'b0;
          cnt_d     = CNT_ZERO;
          discard_d = 1'b0;
          bus_err_d = ~bus_ack_i;
          // A flush seen at any point of the access, including this last
          // cycle, drops the result silently.
          if (discard_q | if_flush_i) begin
            if_ack_d = 1'b0;
          end else begin
            if_ack_d  = 1'b1;
            if_data_d = bus_ack_i ? bus_rdata_i : DATA_ZERO;
          end
        end else begin
          cnt_d     = cnt_q + CNT_ONE;
          discard_d = discard_q | if_flush_i;
        end
      end

      ST_MEM_ACC: begin
        if (finish_s) begin
          state_d   = ST_IDLE;
          bus_cyc_d = 1'b0;
          cnt_d     = CNT_ZERO;
          mem_ack_d = 1'b1;
          bus_err_d = ~bus_ack_i;
          // Stores leave the load-data register untouched.
          if (bus_we_q) begin
            mem_rdata_d = mem_rdata_q;
          end else begin
            mem_rdata_d = bus_ack_i ? bus_rdata_i : DATA_ZERO;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        bus_cyc_d = 1'b0;
        cnt_d     = CNT_ZERO;
        discard_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any access without an ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= CNT_ZERO;
      discard_q   <= 1'b0;
      bus_cyc_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= DATA_ZERO;
      bus_sel_q   <= 4'h0;
      bus_wdata_q <= DATA_ZERO;
      if_data_q   <= DATA_ZERO;
      if_ack_q    <= 1'b0;
      mem_rdata_q <= DATA_ZERO;
      mem_ack_q   <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      discard_q   <= discard_d;
      bus_cyc_q   <= bus_cyc_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_sel_q   <= bus_sel_d;
      bus_wdata_q <= bus_wdata_d;
      if_data_q   <= if_data_d;
      if_ack_q    <= if_ack_d;
      mem_rdata_q <= mem_rdata_d;
      mem_ack_q   <= mem_ack_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus_cyc_o   = bus_cyc_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_sel_o   = bus_sel_q;
  assign bus_wdata_o = bus_wdata_q;
  assign if_data_o   = if_data_q;
  assign if_ack_o    = if_ack_q;
  assign mem_rdata_o = mem_rdata_q;
  assign mem_ack_o   = mem_ack_q;
  assign bus_err_o   = bus_err_q;

  // The stall controller must see a pending request in the same cycle.
  assign stallreq_o = (if_ce_i & ~if_ack_q) | (mem_ce_i & ~mem_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a transaction-level model checked
// every cycle plus directed scenarios with hand-computed expectations.
module tb_mem_arbiter;

  localparam int TO = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_ce_i = 1'b0;
  logic [DW-1:0] if_addr_i = '0;
  logic          if_flush_i = 1'b0;
  logic [DW-1:0] if_data_o;
  logic          if_ack_o;
  logic          mem_ce_i = 1'b0;
  logic          mem_we_i = 1'b0;
  logic [DW-1:0] mem_addr_i = '0;
  logic [3:0]    mem_sel_i = '0;
  logic [DW-1:0] mem_wdata_i = '0;
  logic [DW-1:0] mem_rdata_o;
  logic          mem_ack_o;
  logic          bus_cyc_o;
  logic          bus_we_o;
  logic [DW-1:0] bus_addr_o;
  logic [3:0]    bus_sel_o;
  logic [DW-1:0] bus_wdata_o;
  logic [DW-1:0] bus_rdata_i = '0;
  logic          bus_ack_i = 1'b0;
  logic          bus_err_o;
  logic          stallreq_o;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(TO), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_data_o(if_data_o), .if_ack_o(if_ack_o),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_sel_i(mem_sel_i), .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o),
    .bus_cyc_o(bus_cyc_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .bus_err_o(bus_err_o), .stallreq_o(stallreq_o)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------- transaction-level model ----------------
  // One outstanding access at a time; it is described by its owner, the
  // number of bus cycles it has lasted and whether a flush has hit it.
  bit          m_busy = 1'b0;
  bit          m_is_mem = 1'b0;
  bit          m_drop = 1'b0;
  int          m_age = 0;
  logic        e_cyc = 1'b0, e_we = 1'b0, e_if_ack = 1'b0, e_mem_ack = 1'b0, e_err = 1'b0;
  logic [31:0] e_addr = '0, e_wdata = '0, e_if_data = '0, e_mem_rdata = '0;
  logic [3:0]  e_sel = '0;
  logic        p_if_ack, p_mem_ack;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_busy = 0; m_is_mem = 0; m_drop = 0; m_age = 0;
      e_cyc = 0; e_we = 0; e_if_ack = 0; e_mem_ack = 0; e_err = 0;
      e_addr = '0; e_wdata = '0; e_if_data = '0; e_mem_rdata = '0; e_sel = '0;
    end else begin
      p_if_ack = e_if_ack; p_mem_ack = e_mem_ack;
      e_if_ack = 0; e_mem_ack = 0; e_err = 0;
      if (!m_busy) begin
        if (mem_ce_i && !p_mem_ack) begin
          m_busy = 1; m_is_mem = 1; m_drop = 0; m_age = 1;
          e_cyc = 1; e_we = mem_we_i; e_addr = mem_addr_i; e_sel = mem_sel_i; e_wdata = mem_wdata_i;
        end else if (if_ce_i && !p_if_ack) begin
          m_busy = 1; m_is_mem = 0; m_drop = 0; m_age = 1;
          e_cyc = 1; e_we = 0; e_addr = if_addr_i; e_sel = 4'hF; e_wdata = '0;
        end
      end else begin
        if (!m_is_mem && if_flush_i) m_drop = 1;
        if (bus_ack_i || m_age == TO) begin
          m_busy = 0; e_cyc = 0; e_err = !bus_ack_i;
          if (m_is_mem) begin
            e_mem_ack = 1;
            if (!e_we) e_mem_rdata = bus_ack_i ? bus_rdata_i : 32'h0;
          end else if (!m_drop) begin
            e_if_ack = 1;
            e_if_data = bus_ack_i ? bus_rdata_i : 32'h0;
          end
        end else begin
          m_age++;
        end
      end
    end
  end

  // Every out-of-reset cycle: compare all outputs against the model.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("m_cyc", bus_cyc_o, e_cyc);
      chk("m_addr", bus_addr_o, e_addr);
      chk("m_we", bus_we_o, e_we);
      chk("m_sel", bus_sel_o, e_sel);
      chk("m_wdata", bus_wdata_o, e_wdata);
      chk("m_if_ack", if_ack_o, e_if_ack);
      chk("m_if_data", if_data_o, e_if_data);
      chk("m_mem_ack", mem_ack_o, e_mem_ack);
      chk("m_mem_rdata", mem_rdata_o, e_mem_rdata);
      chk("m_err", bus_err_o, e_err);
      chk("m_stall", stallreq_o, (if_ce_i & ~e_if_ack) | (mem_ce_i & ~e_mem_ack));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_cyc(input string name);
    int k;
    k = 0;
    while (bus_cyc_o !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    chk({name, "_start"}, bus_cyc_o, 1'b1);
  endtask

  // Waits for the access to start, acks it in bus cycle ack_after, and
  // returns in the cycle the completion pulse is visible.
  task automatic run_access(input string name, input logic [31:0] exp_addr,
                            input int ack_after, input logic [31:0] rdata);
    wait_cyc(name);
    chk({name, "_addr"}, bus_addr_o, exp_addr);
    for (int i = 1; i < ack_after; i++) step();
    bus_ack_i = 1'b1; bus_rdata_i = rdata;
    step();
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_cyc", bus_cyc_o, 1'b0);
    chk("rst_addr", bus_addr_o, 32'h0);
    chk("rst_if_data", if_data_o, 32'h0);
    chk("rst_mem_ack", mem_ack_o, 1'b0);
    rst = 1'b0;

    // fetch, acked in the 3rd bus cycle
    if_ce_i = 1'b1; if_addr_i = 32'h100;
    run_access("t1", 32'h100, 3, 32'h3C010001);
    chk("t1_ack", if_ack_o, 1'b1);
    chk("t1_data", if_data_o, 32'h3C010001);
    chk("t1_stall", stallreq_o, 1'b0);
    if_ce_i = 1'b0;
    step();
    chk("t1_ack_once", if_ack_o, 1'b0);

    // simultaneous requests: data port wins, fetch follows right after
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h20; mem_sel_i = 4'hF;
    if_ce_i = 1'b1; if_addr_i = 32'h104;
    run_access("t2m", 32'h20, 1, 32'hA5A50001);
    chk("t2_mem_ack", mem_ack_o, 1'b1);
    chk("t2_mem_rdata", mem_rdata_o, 32'hA5A50001);
    chk("t2_if_wait", if_ack_o, 1'b0);
    mem_ce_i = 1'b0;
    step();
    chk("t2_if_cyc", bus_cyc_o, 1'b1);
    chk("t2_if_addr", bus_addr_o, 32'h104);
    run_access("t2i", 32'h104, 1, 32'h11112222);
    chk("t2_if_data", if_data_o, 32'h11112222);
    if_ce_i = 1'b0;
    step();

    // store, flush during the data access has no effect
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h40; mem_sel_i = 4'hF; mem_wdata_i = 32'hDEADBEEF;
    wait_cyc("t3");
    chk("t3_wdata", bus_wdata_o, 32'hDEADBEEF);
    chk("t3_we", bus_we_o, 1'b1);
    chk("t3_sel", bus_sel_o, 4'hF);
    if_flush_i = 1'b1; bus_ack_i = 1'b1; bus_rdata_i = 32'h99999999;
    step();
    if_flush_i = 1'b0; bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    chk("t3_ack", mem_ack_o, 1'b1);
    chk("t3_rdata_kept", mem_rdata_o, 32'hA5A50001);
    mem_ce_i = 1'b0; mem_we_i = 1'b0;
    step();

    // fetch timeout: no ack for 16 bus cycles
    if_ce_i = 1'b1; if_addr_i = 32'h200;
    wait_cyc("t4");
    for (int i = 2; i <= TO; i++) step();
    chk("t4_still_cyc", bus_cyc_o, 1'b1);
    chk("t4_no_ack_yet", if_ack_o, 1'b0);
    step();
    chk("t4_ack", if_ack_o, 1'b1);
    chk("t4_err", bus_err_o, 1'b1);
    chk("t4_data", if_data_o, 32'h0);
    chk("t4_cyc_drop", bus_cyc_o, 1'b0);
    if_ce_i = 1'b0;
    step();
    chk("t4_err_once", bus_err_o, 1'b0);
    chk("t4_idle", bus_cyc_o, 1'b0);

    // ack arriving on the timeout cycle completes normally
    if_ce_i = 1'b1; if_addr_i = 32'h204;
    wait_cyc("t4b");
    for (int i = 2; i <= TO; i++) step();
    bus_ack_i = 1'b1; bus_rdata_i = 32'h0BADF00D;
    step();
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    chk("t4b_ack", if_ack_o, 1'b1);
    chk("t4b_no_err", bus_err_o, 1'b0);
    chk("t4b_data", if_data_o, 32'h0BADF00D);
    if_ce_i = 1'b0;
    step();

    // bus_ack_i while idle is ignored
    bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFFFFFF;
    step();
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    chk("t_idle_ack_cyc", bus_cyc_o, 1'b0);
    chk("t_idle_ack_data", if_data_o, 32'h0BADF00D);

    // flush in the 2nd bus cycle of a fetch
    if_ce_i = 1'b1; if_addr_i = 32'h300;
    wait_cyc("t5");
    step();
    if_flush_i = 1'b1;
    step();
    if_flush_i = 1'b0;
    bus_ack_i = 1'b1; bus_rdata_i = 32'h12345678;
    step();
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    chk("t5_no_ack", if_ack_o, 1'b0);
    chk("t5_data_kept", if_data_o, 32'h0BADF00D);
    chk("t5_cyc_drop", bus_cyc_o, 1'b0);
    step();
    chk("t5_refetch", bus_cyc_o, 1'b1);
    run_access("t5r", 32'h300, 2, 32'h55AA55AA);
    chk("t5r_ack", if_ack_o, 1'b1);
    chk("t5r_data", if_data_o, 32'h55AA55AA);
    if_ce_i = 1'b0;
    step();

    // asynchronous reset in the middle of a data access
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h60; mem_sel_i = 4'h3;
    wait_cyc("t6");
    step();
    #1;
    rst = 1'b1;
    #1;
    chk("t6_cyc", bus_cyc_o, 1'b0);
    chk("t6_addr", bus_addr_o, 32'h0);
    chk("t6_sel", bus_sel_o, 4'h0);
    chk("t6_mem_rdata", mem_rdata_o, 32'h0);
    chk("t6_if_data", if_data_o, 32'h0);
    chk("t6_acks", {if_ack_o, mem_ack_o, bus_err_o}, 3'b000);
    mem_ce_i = 1'b0;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_no_ack", mem_ack_o, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: bus cycles to wait for bus_ack_i before an access is aborted.
REQ-002 SHALL have parameter DW, default 32: data and address width, equal to RegBus.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 if_ce_i  in  1  fetch request, held until if_ack_o.
REQ-006 if_addr_i  in  DW  fetch address (pc).
REQ-007 if_flush_i  in  1  one-cycle pulse; the in-flight fetch result is discarded.
REQ-008 if_data_o  out  DW  fetched instruction, registered.
REQ-009 if_ack_o  out  1  one-cycle fetch completion.
REQ-010 mem_ce_i  in  1  data request, held until mem_ack_o.
REQ-011 mem_we_i  in  1  1 = store, 0 = load.
REQ-012 mem_addr_i  in  DW  data address.
REQ-013 mem_sel_i  in  4  byte enables.
REQ-014 mem_wdata_i  in  DW  store data.
REQ-015 mem_rdata_o  out  DW  load data, registered.
REQ-016 mem_ack_o  out  1  one-cycle data completion.
REQ-017 bus_cyc_o  out  1  external access active.
REQ-018 bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o  out  1/DW/4/DW  registered bus request fields.
REQ-019 bus_rdata_i  in  DW  bus read data, valid with bus_ack_i.
REQ-020 bus_ack_i  in  1  bus completion.
REQ-021 bus_err_o  out  1  one-cycle pulse on timeout abort.
REQ-022 stallreq_o  out  1  pipeline stall request to the stall controller.

Function
REQ-023 SHALL implement FSM states IDLE, IF_ACC, MEM_ACC.
REQ-024 IDLE: mem_ce_i=1 SHALL win over if_ce_i; the winner's fields SHALL be latched onto bus_* with bus_cyc_o=1 from the next cycle.
REQ-025 IF_ACC / MEM_ACC: bus_* outputs SHALL stay constant until completion.
REQ-026 On bus_ack_i=1, the FSM SHALL capture bus_rdata_i, pulse the matching ack for exactly one cycle, drop bus_cyc_o, and return to IDLE on the same edge.
REQ-027 Minimum latency from ce to ack SHALL be 2 cycles (ack in the first bus cycle); a new access SHALL start no earlier than the cycle after ack.
REQ-028 A wait counter SHALL clear on entry to an ACC state and increment each cycle without bus_ack_i.
REQ-029 When the counter reaches TIMEOUT-1 without ack, the access SHALL complete with data 0, the matching ack pulse, and bus_err_o=1 for one cycle.
REQ-030 bus_ack_i on the timeout cycle SHALL take precedence: normal completion, no bus_err_o.
REQ-031 if_flush_i during IF_ACC SHALL set a discard flag; at completion if_ack_o SHALL stay 0 and if_data_o SHALL be unchanged; the flag SHALL clear on return to IDLE.
REQ-032 if_flush_i in IDLE or MEM_ACC SHALL have no effect.
REQ-033 A store SHALL return mem_rdata_o unchanged, with mem_ack_o still pulsed.
REQ-034 stallreq_o SHALL equal (if_ce_i & ~if_ack_o) | (mem_ce_i & ~mem_ack_o), combinationally.
REQ-035 bus_ack_i in IDLE SHALL be ignored.

Reset
REQ-036 rst=1 SHALL force state IDLE, counter 0, and discard flag 0.
REQ-037 rst=1 SHALL force all outputs to 0: bus_cyc_o, bus_* fields, if_data_o, mem_rdata_o, both acks, bus_err_o.
REQ-038 rst asserted mid-access SHALL abandon the access with no ack generated.

Structure
REQ-039 State encodings and the default TIMEOUT SHALL be defined in defines.v.
REQ-040 The block SHALL be a single module with no sub-modules; the wait counter SHALL be inline.

Verification
REQ-041 if_ce_i=1, if_addr_i=0x100; bus_ack_i on the 3rd bus cycle with rdata 0x3C010001 -> if_data_o=0x3C010001, if_ack_o high one cycle, stallreq_o low that cycle.
REQ-042 if_ce_i and mem_ce_i rise together (mem load at addr 0x20) -> bus_addr_o=0x20 first; fetch starts the cycle after mem_ack_o.
REQ-043 mem store, we=1, sel=0xF, wdata=0xDEADBEEF, ack after 1 cycle -> bus_wdata_o=0xDEADBEEF, mem_ack_o pulses, mem_rdata_o unchanged.
REQ-044 No bus_ack_i for 16 cycles on a fetch -> if_ack_o and bus_err_o pulse in the 16th bus cycle, if_data_o=0, FSM back in IDLE.
REQ-045 if_flush_i pulsed in the 2nd cycle of IF_ACC, ack with 0x12345678 -> no if_ack_o, if_data_o unchanged, next fetch proceeds normally.
REQ-046 rst asserted during MEM_ACC -> all outputs 0 immediately (asynchronous); no mem_ack_o after release.
